scan_mod_counter: RTL and testbench

- Parametrised successor to the 4-bit scan-enabled counter: WIDTH-bit modulo-N up/down counter with parallel load, count enable, terminal-count strobe and a sticky wrap flag.
- Every state flop (count register plus wrap flag) sits on one internal scan chain driven by SE/scan_in/scan_out.
- Drops into the physical-design lab flow (synthesis, scan insertion check, SDF gate-level sim) as the general counter primitive.

---
 rtl/scan_ctr_pkg.sv | 22 ++
 rtl/scan_mod_counter_if.sv | 30 +++
 rtl/scan_cell.sv | 29 ++
 rtl/scan_mod_counter.sv | 137 +++++++++++++
 tb/tb_scan_mod_counter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_ctr_pkg.sv
// Shared definitions for the scan-enabled modulo-N counter: parameter
// legal ranges, scan-chain length helper and the per-edge operation encoding.
package scan_ctr_pkg;

  localparam int     WIDTH_MIN   = 2;
  localparam int     WIDTH_MAX   = 32;
  localparam longint MODULUS_MIN = 64'sd2;

  // Operation selected on a clock edge (reset is handled inside each cell).
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2,
    OP_SHIFT = 2'd3
  } op_e;

  // Every count bit plus the sticky wrap flag sits on the chain.
  function automatic int chain_len(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/scan_mod_counter_if.sv
// Groups the functional and scan signals of scan_mod_counter so a driver
// (master) and the counter side (slave) can share one bundle.
interface scan_mod_counter_if #(
  parameter int WIDTH = 4
);
  import scan_ctr_pkg::*;

  logic             SE;
  logic             scan_in;
  logic             scan_out;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_wrap;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_flag;

  modport master (
    output SE, scan_in, en, up, load, load_val, clr_wrap,
    input  scan_out, count, tc, wrap_flag
  );

  modport slave (
    input  SE, scan_in, en, up, load, load_val, clr_wrap,
    output scan_out, count, tc, wrap_flag
  );

endinterface

// File: rtl/scan_cell.sv
// Single-bit mux-D scan flop: synchronous active-low reset, then scan data
// when SE is high, otherwise the functional next-state bit.
module scan_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic se_i,
  input  logic d_i,
  input  logic si_i,
  output logic q_o
);

  logic q_q;

  // Reset has priority over shift, shift over functional capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else if (se_i) begin
      q_q <= si_i;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with parallel load, terminal-count
// strobe and sticky wrap flag. All state lives in an explicit chain of
// scan_cell instances: scan_in -> count[0] .. count[WIDTH-1] -> wrap -> scan_out.
module scan_mod_counter
  import scan_ctr_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 64'sd16,
  parameter longint RESET_VAL = 64'sd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SE,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_flag
);

  localparam int CHAIN_LEN = chain_len(WIDTH);

  // Elaboration-time parameter legality checks.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("scan_mod_counter: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (MODULUS < MODULUS_MIN || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
    $error("scan_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if (RESET_VAL < 64'sd0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("scan_mod_counter: RESET_VAL %0d must be below MODULUS", RESET_VAL);
  end

  // Largest legal count; for MODULUS == 2**WIDTH this is all ones, which
  // makes the wrap identical to natural binary overflow.
  localparam logic [WIDTH-1:0]     MAX_VAL   = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0]     ZERO_VAL  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONE_VAL   = WIDTH'(64'sd1);
  localparam logic [CHAIN_LEN-1:0] RST_CHAIN = {1'b0, WIDTH'(RESET_VAL)};

  op_e                  op_s;
  logic                 tc_s;
  logic [WIDTH-1:0]     count_q;
  logic                 wrap_q;
  logic [WIDTH-1:0]     count_d;
  logic                 wrap_d;
  logic [CHAIN_LEN-1:0] chain_q;
  logic [CHAIN_LEN-1:0] func_d_s;
  logic [CHAIN_LEN-1:0] scan_d_s;

  assign count_q = chain_q[WIDTH-1:0];
  assign wrap_q  = chain_q[CHAIN_LEN-1];

  // Decode the operation for this edge: shift beats load beats count.
  always_comb begin
    op_s = OP_HOLD;
    if (SE) begin
      op_s = OP_SHIFT;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (en) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Terminal count: the counter will roll over on the coming edge. Any
  // out-of-range value left by a shift is treated as the top of the range.
  always_comb begin
    tc_s = 1'b0;
    if (op_s == OP_COUNT) begin
      if (up) begin
        tc_s = (count_q >= MAX_VAL);
      end else begin
        tc_s = (count_q == ZERO_VAL);
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  // Functional next state for count and the sticky wrap flag; a wrap on the
  // same edge as clr_wrap leaves the flag set.
  always_comb begin
    count_d = count_q;
    wrap_d  = tc_s | (wrap_q & ~clr_wrap);
    case (op_s)
      OP_LOAD: begin
        if (load_val > MAX_VAL) begin
          count_d = MAX_VAL;
        end else begin
          count_d = load_val;
        end
      end
      OP_COUNT: begin
        if (tc_s) begin
          count_d = up ? ZERO_VAL : MAX_VAL;
        end else if (up) begin
          count_d = count_q + ONE_VAL;
        end else begin
          count_d = count_q - ONE_VAL;
        end
      end
      OP_HOLD:  count_d = count_q;
      OP_SHIFT: count_d = count_q;
      default:  count_d = count_q;
    endcase
  end

  assign func_d_s = {wrap_d, count_d};
  assign scan_d_s = {chain_q[CHAIN_LEN-2:0], scan_in};

  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_chain
    scan_cell #(
      .RST_VAL(RST_CHAIN[i])
    ) u_cell (
      .clk_i (clk),
      .rst_ni(reset),
      .se_i  (SE),
      .d_i   (func_d_s[i]),
      .si_i  (scan_d_s[i]),
      .q_o   (chain_q[i])
    );
  end

  assign count     = count_q;
  assign wrap_flag = wrap_q;
  assign scan_out  = wrap_q;
  assign tc        = tc_s;

endmodule

// File: tb/tb_scan_mod_counter.sv
// Self-checking bench for scan_mod_counter (WIDTH=4, MODULUS=10, RESET_VAL=0).
// A behavioural model pushes the expected post-edge state into a scoreboard
// when stimulus is driven; it is popped and compared after the edge.
module tb_scan_mod_counter;

  typedef struct {
    logic [3:0] count;
    logic       wrap;
  } exp_t;

  logic clk;
  logic reset_s;
  int   checks;
  int   failures;

  exp_t       sb[$];
  logic [3:0] m_count;
  logic       m_wrap;
  logic       m_valid;

  scan_mod_counter_if #(.WIDTH(4)) bus ();

  scan_mod_counter #(
    .WIDTH    (4),
    .MODULUS  (64'sd10),
    .RESET_VAL(64'sd0)
  ) dut (
    .clk      (clk),
    .reset    (reset_s),
    .SE       (bus.SE),
    .scan_in  (bus.scan_in),
    .scan_out (bus.scan_out),
    .en       (bus.en),
    .up       (bus.up),
    .load     (bus.load),
    .load_val (bus.load_val),
    .clr_wrap (bus.clr_wrap),
    .count    (bus.count),
    .tc       (bus.tc),
    .wrap_flag(bus.wrap_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs (called just after a falling edge), check tc and
  // scan_out before the rising edge, push the model's next state, then
  // compare count/wrap just after the edge and return at the next falling edge.
  task automatic drive_cycle(input logic rst_v, input logic se_v, input logic si_v,
                             input logic en_v, input logic up_v, input logic ld_v,
                             input logic [3:0] lv_v, input logic cw_v);
    exp_t       e;
    exp_t       got;
    logic       tc_exp;
    reset_s      = rst_v;
    bus.SE       = se_v;
    bus.scan_in  = si_v;
    bus.en       = en_v;
    bus.up       = up_v;
    bus.load     = ld_v;
    bus.load_val = lv_v;
    bus.clr_wrap = cw_v;
    #1;
    tc_exp = 1'b0;
    if (m_valid) begin
      tc_exp = !se_v && !ld_v && en_v &&
               ((up_v && m_count >= 4'd9) || (!up_v && m_count == 4'd0));
      checks++;
      if (bus.tc !== tc_exp) begin
        failures++;
        $display("FAIL tc: got %b expected %b (count model %0d)", bus.tc, tc_exp, m_count);
      end
      checks++;
      if (bus.scan_out !== m_wrap) begin
        failures++;
        $display("FAIL scan_out: got %b expected %b", bus.scan_out, m_wrap);
      end
    end
    if (!rst_v) begin
      e.count = 4'd0;
      e.wrap  = 1'b0;
    end else if (se_v) begin
      e.wrap  = m_count[3];
      e.count = {m_count[2:0], si_v};
    end else if (ld_v) begin
      e.count = (lv_v > 4'd9) ? 4'd9 : lv_v;
      e.wrap  = m_wrap && !cw_v;
    end else if (en_v) begin
      if (up_v) e.count = (m_count >= 4'd9) ? 4'd0 : m_count + 4'd1;
      else      e.count = (m_count == 4'd0) ? 4'd9 : m_count - 4'd1;
      e.wrap = tc_exp || (m_wrap && !cw_v);
    end else begin
      e.count = m_count;
      e.wrap  = m_wrap && !cw_v;
    end
    if (m_valid || !rst_v) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      if (bus.count !== got.count) begin
        failures++;
        $display("FAIL count: got %0d expected %0d", bus.count, got.count);
      end
      checks++;
      if (bus.wrap_flag !== got.wrap) begin
        failures++;
        $display("FAIL wrap_flag: got %b expected %b", bus.wrap_flag, got.wrap);
      end
      m_count = got.count;
      m_wrap  = got.wrap;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (bus.count !== 4'd0 || bus.wrap_flag !== 1'b0 || bus.scan_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got count=%0d wrap=%b so=%b expected 0/0/0",
               bus.count, bus.wrap_flag, bus.scan_out);
    end
  endtask

  task automatic test_count_up();
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      checks++;
      if (bus.count !== 4'(k % 10)) begin
        failures++;
        $display("FAIL count_up_seq: step %0d got %0d expected %0d", k, bus.count, k % 10);
      end
      checks++;
      if (bus.wrap_flag !== (k >= 10)) begin
        failures++;
        $display("FAIL count_up_wrap: step %0d got %b expected %b", k, bus.wrap_flag, (k >= 10));
      end
    end
  endtask

  task automatic test_down_load();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hE, 1'b0);
    checks++;
    if (bus.count !== 4'd9) begin
      failures++;
      $display("FAIL load_clamp: got %0d expected 9", bus.count);
    end
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checks++;
      if (bus.count !== 4'((19 - k) % 10)) begin
        failures++;
        $display("FAIL count_down_seq: step %0d got %0d expected %0d", k, bus.count, (19 - k) % 10);
      end
    end
  endtask

  task automatic test_scan_in();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b1, pat[4 - k], 1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    end
    checks++;
    if (bus.count !== 4'b0101 || bus.wrap_flag !== 1'b1) begin
      failures++;
      $display("FAIL scan_in: got count=%b wrap=%b expected 0101/1", bus.count, bus.wrap_flag);
    end
  endtask

  task automatic test_scan_out();
    logic [4:0] stream;
    logic [4:0] want;
    want = 5'b10111;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stream[4 - k] = bus.scan_out;
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    end
    checks++;
    if (stream !== want) begin
      failures++;
      $display("FAIL scan_out_stream: got %b expected %b", stream, want);
    end
    checks++;
    if (bus.count !== 4'd0 || bus.wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL scan_out_flush: got count=%0d wrap=%b expected 0/0", bus.count, bus.wrap_flag);
    end
  endtask

  task automatic test_simultaneous();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (bus.count !== 4'd0 || bus.wrap_flag !== 1'b1) begin
      failures++;
      $display("FAIL wrap_beats_clr: got count=%0d wrap=%b expected 0/1", bus.count, bus.wrap_flag);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (bus.wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL clr_wrap: got %b expected 0", bus.wrap_flag);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    checks++;
    if (bus.count !== 4'd3) begin
      failures++;
      $display("FAIL load_beats_en: got %0d expected 3", bus.count);
    end
  endtask

  task automatic test_reset_midshift();
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (bus.count !== 4'd0 || bus.wrap_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_midshift: got count=%0d wrap=%b expected 0/0", bus.count, bus.wrap_flag);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (bus.count !== 4'd1) begin
      failures++;
      $display("FAIL shift_resume: got %0d expected 1", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      drive_cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_valid      = 1'b0;
    m_count      = 4'd0;
    m_wrap       = 1'b0;
    reset_s      = 1'b0;
    bus.SE       = 1'b0;
    bus.scan_in  = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.clr_wrap = 1'b0;
    @(negedge clk);
    test_reset();
    test_count_up();
    test_down_load();
    test_scan_in();
    test_scan_out();
    test_simultaneous();
    test_reset_midshift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
